// File: rtl/dbg_pkg.sv
// Shared types and character codes for the debug pager display.
// Pages cycle CC, PC, Ad, IN, ST, OP on six 7-segment digits.
package dbg_pkg;

  localparam int NUM_PAGES = 6;

  typedef enum logic [2:0] {
    PG_CC = 3'd0,
    PG_PC = 3'd1,
    PG_AD = 3'd2,
    PG_IN = 3'd3,
    PG_ST = 3'd4,
    PG_OP = 3'd5
  } page_t;

  localparam logic [7:0] CH_A   = 8'd65;
  localparam logic [7:0] CH_C   = 8'd67;
  localparam logic [7:0] CH_D   = 8'd68;
  localparam logic [7:0] CH_I   = 8'd73;
  localparam logic [7:0] CH_N   = 8'd78;
  localparam logic [7:0] CH_O   = 8'd79;
  localparam logic [7:0] CH_P   = 8'd80;
  localparam logic [7:0] CH_S   = 8'd83;
  localparam logic [7:0] CH_T   = 8'd84;
  localparam logic [7:0] CH_OFF = 8'd127;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return {4'h0, n};
  endfunction

  function automatic page_t next_page(input page_t p);
    return (p == PG_OP) ? PG_CC : page_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer plus tick-based debounce.
// rise pulses for one cycle when the accepted level goes 0->1.
module debounce #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (tick) begin
        if (s2 == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          cnt   <= '0;
          level <= s2;
          rise  <= s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dbg_pager.sv
// Debug pager: steps through six CPU register pages on a
// button press or dwell timeout, driving six character digits.
module dbg_pager
  import dbg_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int DWELL_TICKS    = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_next,
  input  logic        auto_en,
  input  logic [15:0] cc,
  input  logic [15:0] pc,
  input  logic [15:0] ad,
  input  logic [7:0]  in_reg,
  input  logic [7:0]  st,
  input  logic [7:0]  op,
  output logic [2:0]  page,
  output logic [47:0] digits
);

  localparam int DW = $clog2(DWELL_TICKS + 1);

  page_t         pg;
  logic [DW-1:0] dwell;
  logic          reload;
  logic          level;
  logic          rise;
  logic          press;
  logic          expire;
  logic          adv;

  debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .raw  (btn_next),
    .level(level),
    .rise (rise)
  );

  assign press  = rise & level;
  assign expire = auto_en & tick &
                  (dwell == DW'(DWELL_TICKS - 1));
  assign adv    = press | expire;
  assign page   = pg;

  logic [7:0]  lab5;
  logic [7:0]  lab4;
  logic [15:0] val;
  logic        wide;
  logic [47:0] shown;

  always_comb begin
    lab5 = CH_OFF;
    lab4 = CH_OFF;
    val  = '0;
    wide = 1'b0;
    case (pg)
      PG_CC: begin
        lab5 = CH_C; lab4 = CH_C; val = cc; wide = 1'b1;
      end
      PG_PC: begin
        lab5 = CH_P; lab4 = CH_C; val = pc; wide = 1'b1;
      end
      PG_AD: begin
        lab5 = CH_A; lab4 = CH_D; val = ad; wide = 1'b1;
      end
      PG_IN: begin
        lab5 = CH_I; lab4 = CH_N; val = {8'h00, in_reg};
      end
      PG_ST: begin
        lab5 = CH_S; lab4 = CH_T; val = {8'h00, st};
      end
      PG_OP: begin
        lab5 = CH_O; lab4 = CH_P; val = {8'h00, op};
      end
      default: ;
    endcase
  end

  always_comb begin
    if (wide) begin
      shown = {lab5, lab4,
               hex(val[15:12]), hex(val[11:8]),
               hex(val[7:4]), hex(val[3:0])};
    end else begin
      shown = {lab5, lab4, CH_OFF, CH_OFF,
               hex(val[7:4]), hex(val[3:0])};
    end
  end

  // A page change forces a reload next cycle so the new label shows at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      pg     <= PG_CC;
      dwell  <= '0;
      reload <= 1'b0;
      digits <= {6{CH_OFF}};
    end else begin
      reload <= adv;
      if (adv) begin
        pg    <= next_page(pg);
        dwell <= '0;
      end else if (auto_en && tick) begin
        dwell <= dwell + 1'b1;
      end
      if (tick || reload) begin
        digits <= shown;
      end
    end
  end

endmodule

// File: tb/tb_dbg_pager.sv
// Randomized and directed bench for dbg_pager against a
// behavioural page/display model.
module tb_dbg_pager;

  localparam int DB = 20;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        btn_next = 1'b0;
  logic        auto_en = 1'b0;
  logic [15:0] cc = '0;
  logic [15:0] pc = '0;
  logic [15:0] ad = '0;
  logic [7:0]  in_reg = '0;
  logic [7:0]  st = '0;
  logic [7:0]  op = '0;
  logic [2:0]  page;
  logic [47:0] digits;

  always #5 clk = ~clk;

  dbg_pager #(
    .DEBOUNCE_TICKS(DB),
    .DWELL_TICKS   (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .btn_next(btn_next),
    .auto_en (auto_en),
    .cc      (cc),
    .pc      (pc),
    .ad      (ad),
    .in_reg  (in_reg),
    .st      (st),
    .op      (op),
    .page    (page),
    .digits  (digits)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model
  int          lab5[6] = '{67, 80, 65, 73, 83, 79};
  int          lab4[6] = '{67, 67, 68, 78, 84, 80};
  int          m_page = 0;
  int          m_dwell = 0;
  int          m_db = 0;
  bit          m_level = 0;
  bit          m_press = 0;
  bit          m_reload = 0;
  bit          m_pipe[$] = '{0, 0};
  logic [47:0] m_digits = {6{8'd127}};
  bit          cmp_en = 0;

  function automatic logic [47:0] render(int pg);
    logic [15:0] v;
    int          d[6];
    logic [47:0] r;
    case (pg)
      0: v = cc;
      1: v = pc;
      2: v = ad;
      3: v = {8'h00, in_reg};
      4: v = {8'h00, st};
      default: v = {8'h00, op};
    endcase
    d[5] = lab5[pg];
    d[4] = lab4[pg];
    if (pg < 3) begin
      for (int k = 0; k < 4; k++) d[k] = (v >> (4 * k)) & 15;
    end else begin
      d[3] = 127;
      d[2] = 127;
      d[1] = (v >> 4) & 15;
      d[0] = v & 15;
    end
    r = '0;
    for (int k = 0; k < 6; k++) r[8*k +: 8] = d[k][7:0];
    return r;
  endfunction

  always @(posedge clk) begin
    bit seen;
    bit expire;
    bit adv;
    bit np;
    if (reset) begin
      m_page = 0; m_dwell = 0; m_db = 0; m_level = 0;
      m_press = 0; m_reload = 0;
      m_pipe = '{0, 0};
      m_digits = {6{8'd127}};
    end else begin
      expire = auto_en && tick && (m_dwell + 1 == DW);
      adv = m_press || expire;
      if (tick || m_reload) m_digits = render(m_page);
      m_reload = adv;
      if (adv) begin
        m_page = (m_page + 1) % 6;
        m_dwell = 0;
      end else if (auto_en && tick) begin
        m_dwell = m_dwell + 1;
      end
      seen = m_pipe.pop_front();
      m_pipe.push_back(btn_next);
      np = 0;
      if (tick) begin
        if (seen != m_level) begin
          m_db++;
          if (m_db == DB) begin
            m_level = seen;
            np = seen;
            m_db = 0;
          end
        end else begin
          m_db = 0;
        end
      end
      m_press = np;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_page", page, m_page);
      check("model_digits", digits, m_digits);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_once();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic press();
    btn_next = 1'b1;
    cyc(3);
    repeat (DB + 1) tick_once();
    btn_next = 1'b0;
    cyc(3);
    repeat (DB + 1) tick_once();
    cyc(3);
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  localparam logic [47:0] ALL_OFF = {6{8'd127}};

  initial begin
    cyc(3);
    cmp_en = 1;
    check("reset_page", page, 0);
    check("reset_digits", digits, ALL_OFF);
    reset = 1'b0;
    cyc(5);
    check("off_until_tick", digits, ALL_OFF);

    press();
    check("press_page1", page, 1);
    pc = 16'hBEEF;
    tick_once();
    cyc(1);
    check("pc_beef", digits,
          {8'd80, 8'd67, 8'd11, 8'd14, 8'd14, 8'd15});

    press();
    press();
    check("press_page3", page, 3);
    in_reg = 8'hA9;
    tick_once();
    cyc(1);
    check("in_a9", digits,
          {8'd73, 8'd78, 8'd127, 8'd127, 8'd10, 8'd9});

    btn_next = 1'b1;
    cyc(3);
    repeat (5) tick_once();
    btn_next = 1'b0;
    repeat (25) tick_once();
    cyc(3);
    check("glitch_no_adv", page, 3);

    btn_next = 1'b1;
    cyc(3);
    repeat (DB - 1) tick_once();
    cyc(3);
    check("hold_19_no_adv", page, 3);
    tick_once();
    cyc(3);
    check("hold_20_adv", page, 4);
    btn_next = 1'b0;
    repeat (25) tick_once();
    cyc(3);
    check("release_no_adv", page, 4);

    pulse_reset();
    auto_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      repeat (DW - 1) tick_once();
      cyc(2);
      check("auto_hold", page, (i - 1) % 6);
      tick_once();
      cyc(2);
      check("auto_step", page, i % 6);
    end

    repeat (DW - 1) tick_once();
    pulse_reset();
    cyc(1);
    check("mid_dwell_rst_page", page, 0);
    check("mid_dwell_rst_digits", digits, ALL_OFF);
    repeat (DW - 1) tick_once();
    cyc(2);
    check("post_rst_hold", page, 0);
    tick_once();
    cyc(2);
    check("post_rst_adv", page, 1);
    auto_en = 1'b0;

    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 2500; n++) begin
        @(negedge clk);
        reset = ($urandom_range(0, 799) == 0);
        tick = (seg[0]) ? 1'b1 : ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, seg[0] ? 29 : 99) == 0)
          btn_next = ~btn_next;
        if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
        cc = 16'($urandom);
        pc = 16'($urandom);
        ad = 16'($urandom);
        in_reg = 8'($urandom);
        st = 8'($urandom);
        op = 8'($urandom);
      end
    end
    reset = 1'b0;
    tick = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
